// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl
//   Sequencer for an ECP5 EHXPLLL. It pulses the PLL reset, qualifies LOCK
//   through a consecutive-cycle filter, holds the downstream system reset
//   until the clock has been stable for SYS_HOLD cycles, and executes dynamic
//   phase-shift requests on PHASESEL/PHASEDIR/PHASESTEP.
//
// Ports
//   clock, reset        PLL reference clock; synchronous active-high reset
//   pll_locked          raw PLL LOCK (asynchronous, synchronized here)
//   pll_rst             PLL RST
//   phasesel/phasedir   selected output / direction (1 = lead)
//   phasestep           active-low step strobe, idle high
//   phaseloadreg        tied high
//   req_valid/req_ready request handshake, req_sel/req_dir/req_steps payload
//   clk_ok, sys_reset   filtered lock status, downstream reset
//   busy, done, abort   status; done/abort are one-cycle pulses
`timescale 1ns/1ps
module pll_phase_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int SYS_HOLD     = 16,
  parameter int STEP_PULSE   = 4,
  parameter int STEP_GAP     = 8,
  parameter int CW           = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pll_locked,
  output logic          pll_rst,
  output logic [1:0]    phasesel,
  output logic          phasedir,
  output logic          phasestep,
  output logic          phaseloadreg,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_sel,
  input  logic          req_dir,
  input  logic [CW-1:0] req_steps,
  output logic          clk_ok,
  output logic          sys_reset,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  // One general-purpose cycle counter serves PLLRST, HOLD, SETUP, STEP_LO and
  // STEP_GAP; it is sized for the longest of those intervals.
  localparam int MAX_A = (RST_CYCLES > SYS_HOLD) ? RST_CYCLES : SYS_HOLD;
  localparam int MAX_B = (STEP_PULSE > STEP_GAP) ? STEP_PULSE : STEP_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int GMAX  = (MAX_C > 2) ? MAX_C : 2;
  localparam int GW    = $clog2(GMAX + 1);
  localparam int FW    = $clog2(LOCK_FILTER + 1);
  localparam int TW    = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [GW-1:0] RST_LAST   = GW'(RST_CYCLES - 1);
  localparam logic [GW-1:0] HOLD_LAST  = GW'(SYS_HOLD - 1);
  localparam logic [GW-1:0] SETUP_LAST = GW'(1);
  localparam logic [GW-1:0] PULSE_LAST = GW'(STEP_PULSE - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STEP_GAP - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_PLLRST, S_WAIT_LOCK, S_HOLD, S_IDLE, S_SETUP, S_STEP_LO, S_STEP_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [1:0]    sel_q, sel_d;
  logic          dir_q, dir_d;
  logic          lock_meta_q, lock_s_q;
  logic          pll_rst_q, pll_rst_d;
  logic          phasestep_q, phasestep_d;
  logic          req_ready_q, req_ready_d;
  logic          clk_ok_q, clk_ok_d;
  logic          sys_reset_q, sys_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          locked_state;

  // States that require a qualified clock; losing lock_s in any of them
  // drops back to WAIT_LOCK.
  assign locked_state = (state_q == S_HOLD)    || (state_q == S_IDLE)    ||
                        (state_q == S_SETUP)   || (state_q == S_STEP_LO) ||
                        (state_q == S_STEP_GAP)|| (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + GW'(1);
    filt_d  = '0;
    tmo_d   = '0;
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    abort_d = 1'b0;

    case (state_q)
      S_PLLRST:    if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        filt_d = lock_s_q ? (filt_q + FW'(1)) : '0;
        tmo_d  = tmo_q + TW'(1);
        if (lock_s_q && (filt_q == FILT_LAST)) state_d = S_HOLD;
        else if (tmo_q == TMO_LAST)            state_d = S_PLLRST;
      end
      S_HOLD:      if (cnt_q == HOLD_LAST) state_d = S_IDLE;
      S_IDLE: begin
        if (req_valid) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          state_d = (req_steps == '0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP:     if (cnt_q == SETUP_LAST) state_d = S_STEP_LO;
      S_STEP_LO:   if (cnt_q == PULSE_LAST) state_d = S_STEP_GAP;
      S_STEP_GAP: begin
        if (cnt_q == GAP_LAST) begin
          steps_d = steps_q - CW'(1);
          state_d = (steps_q == CW'(1)) ? S_DONE : S_STEP_LO;
        end
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_PLLRST;
    endcase

    // Lock loss overrides everything. A request accepted in the same IDLE
    // cycle counts as in flight, so it is reported as aborted.
    if (locked_state && !lock_s_q) begin
      state_d = S_WAIT_LOCK;
      abort_d = (state_q != S_HOLD) && ((state_q != S_IDLE) || req_valid);
    end

    if (state_d != state_q)     cnt_d = '0;
    if (state_d != S_WAIT_LOCK) begin
      filt_d = '0;
      tmo_d  = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    pll_rst_d   = (state_d == S_PLLRST);
    phasestep_d = (state_d != S_STEP_LO);
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    clk_ok_d    = (state_d == S_HOLD)    || (state_d == S_IDLE)     ||
                  (state_d == S_SETUP)   || (state_d == S_STEP_LO)  ||
                  (state_d == S_STEP_GAP)|| (state_d == S_DONE);
    sys_reset_d = !((state_d == S_IDLE)  || (state_d == S_SETUP)    ||
                    (state_d == S_STEP_LO)|| (state_d == S_STEP_GAP)||
                    (state_d == S_DONE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_PLLRST;
      cnt_q       <= '0;
      filt_q      <= '0;
      tmo_q       <= '0;
      steps_q     <= '0;
      sel_q       <= '0;
      dir_q       <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b1;
      phasestep_q <= 1'b1;
      req_ready_q <= 1'b0;
      clk_ok_q    <= 1'b0;
      sys_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      tmo_q       <= tmo_d;
      steps_q     <= steps_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      pll_rst_q   <= pll_rst_d;
      phasestep_q <= phasestep_d;
      req_ready_q <= req_ready_d;
      clk_ok_q    <= clk_ok_d;
      sys_reset_q <= sys_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b1;
  assign req_ready    = req_ready_q;
  assign clk_ok       = clk_ok_q;
  assign sys_reset    = sys_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign abort        = abort_q;

endmodule
